// File: rtl/ame_sched_pkg.sv
// Shared state encoding and default sizing for the approximation scheduler.
package ame_sched_pkg;

    localparam int unsigned NumReqDefault       = 4;
    localparam int unsigned TagDepthDefault     = 8;
    localparam int unsigned CompDataBitsDefault = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ame_tag_fifo.sv
// Tag FIFO: remembers which requester owns each in-flight operation, in issue order.
module ame_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AddrBits = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [AddrBits-1:0] wr_ptr;
    logic [AddrBits-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == (AddrBits + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the empty flag guards stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ame_num_sched.sv
// Round-robin scheduler sharing one in-order ame_num_approx pipeline among requesters.
module ame_num_sched
    import ame_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NumReqDefault,
    parameter int unsigned COMP_DATA_BITS = CompDataBitsDefault,
    parameter int unsigned TAG_DEPTH      = TagDepthDefault
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                sched_en_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ*COMP_DATA_BITS-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic                                comp_init_o,
    output logic [COMP_DATA_BITS-1:0]           comp_data_o,
    input  logic                                comp_done_i,
    input  logic [$clog2(COMP_DATA_BITS)-1:0]   comp_data_i,
    output logic                                rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]          rsp_id_o,
    output logic [$clog2(COMP_DATA_BITS)-1:0]   rsp_data_o,
    output logic                                busy_o,
    output logic                                err_o
);
    localparam int unsigned IdBits  = $clog2(NUM_REQ);
    localparam int unsigned CntBits = $clog2(TAG_DEPTH) + 1;

    sched_state_e                state;
    logic [IdBits-1:0]           ptr;
    logic [IdBits:0]             cand;
    logic [IdBits-1:0]           grant_idx;
    logic                        found;
    logic                        can_grant;
    logic [NUM_REQ-1:0]          grant;
    logic                        transfer;
    logic                        pop;
    logic                        spurious;
    logic [COMP_DATA_BITS-1:0]   operand;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [IdBits-1:0]           head_tag;
    logic [CntBits-1:0]          outstanding;

    // Round-robin search: first valid requester at or after ptr, modulo NUM_REQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IdBits + 1)'(k);
            if (cand >= (IdBits + 1)'(NUM_REQ)) cand = cand - (IdBits + 1)'(NUM_REQ);
            if (!found && req_valid_i[cand[IdBits-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IdBits-1:0];
            end
        end
    end

    // Grant only while running, enabled and with a free tag slot.
    assign can_grant = (state == StRun) && sched_en_i && !fifo_full;

    // One-hot ready from the search result.
    always_comb begin
        grant = '0;
        if (can_grant && found) grant[grant_idx] = 1'b1;
    end

    assign req_ready_o = grant;
    assign transfer    = |(grant & req_valid_i);
    assign pop         = comp_done_i && !fifo_empty;
    assign spurious    = comp_done_i && fifo_empty;
    assign busy_o      = (state != StIdle);

    // Operand of the granted requester.
    always_comb begin
        operand = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) operand = req_data_i[k*COMP_DATA_BITS +: COMP_DATA_BITS];
        end
    end

    // Control FSM: drain waits for every outstanding result before going idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= StIdle;
        end else begin
            unique case (state)
                StIdle: begin
                    if (sched_en_i) state <= StRun;
                end
                StRun: begin
                    if (!sched_en_i) state <= (outstanding != '0) ? StDrain : StIdle;
                end
                StDrain: begin
                    if (sched_en_i)              state <= StRun;
                    else if (outstanding == '0) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Arbitration pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (grant_idx == IdBits'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Sticky error: a result arrived with no tag to match it against.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_o <= 1'b0;
        end else if (spurious) begin
            err_o <= 1'b1;
        end
    end

    // Issue register towards the approximation pipeline; data holds between issues.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            comp_init_o <= 1'b0;
            comp_data_o <= '0;
        end else begin
            comp_init_o <= transfer;
            if (transfer) comp_data_o <= operand;
        end
    end

    // Response register: pair each returning result with the oldest tag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= pop;
            if (pop) begin
                rsp_id_o   <= head_tag;
                rsp_data_o <= comp_data_i;
            end
        end
    end

    ame_tag_fifo #(
        .WIDTH (IdBits),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .push  (transfer),
        .wdata (grant_idx),
        .pop   (pop),
        .rdata (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

endmodule
